// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives instruction memory, buffers words in a small prefetch FIFO.
// Optional FETCH_PERF_EN adds a saturating decode-stall counter (stall_cnt).
module instr_fetch_unit #(
    parameter int ADDR_W = 6,
    parameter int INSTR_W = 32,
    parameter int FIFO_DEPTH = 2,
    parameter logic [INSTR_W-1:0] HALT_WORD = {INSTR_W{1'b1}}
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_rd_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redir_valid,
    input  logic [ADDR_W-1:0]  redir_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               out_ready,
    output logic               halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_rsp_pc;
    logic               r_inflight;
    logic               r_halt_pending;
    logic               r_halted;
    logic [INSTR_W-1:0] r_mem_instr [FIFO_DEPTH];
    logic [ADDR_W-1:0]  r_mem_pc [FIFO_DEPTH];
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;

    logic               w_redir;
    logic               w_rsp_halt;
    logic               w_set_halt;
    logic               w_push;
    logic               w_pop;
    logic               w_issue;
    logic [CW-1:0]      w_used;

    // Redirects are ignored once halted; a response in a redirect cycle is dropped.
    assign w_redir    = redir_valid & ~r_halted;
    assign w_rsp_halt = r_inflight & (imem_rdata == HALT_WORD);
    assign w_set_halt = w_rsp_halt & ~w_redir;
    assign w_push     = r_inflight & ~w_redir & ~w_rsp_halt;
    assign w_pop      = out_valid & out_ready;

    // Slots committed after this cycle; a same-cycle pop frees a slot for issue.
    assign w_used  = r_count + CW'(r_inflight) - CW'(w_pop);
    // A HALT arriving this cycle also blocks issue so no stray word follows it.
    assign w_issue = rst_n & ~r_halt_pending & ~r_halted & ~redir_valid
                   & ~w_set_halt & (w_used < CW'(FIFO_DEPTH));

    assign imem_rd_en = w_issue;
    assign imem_addr  = r_pc;
    assign out_valid  = (r_count != '0);
    assign out_instr  = out_valid ? r_mem_instr[r_rptr] : '0;
    assign out_pc     = out_valid ? r_mem_pc[r_rptr] : '0;
    assign halted     = r_halted;

    // Program counter and the single outstanding read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= '0;
            r_rsp_pc   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rsp_pc <= r_pc;
            end
            if (w_redir) begin
                r_pc <= redir_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + ADDR_W'(1);
            end
        end
    end

    // FIFO storage; contents are only observed through valid entries.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wptr] <= imem_rdata;
            r_mem_pc[r_wptr]    <= r_rsp_pc;
        end
    end

    // FIFO pointers and occupancy, flushed by a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_redir) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // HALT tracking: pending until the FIFO drains, then sticky halted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halt_pending <= 1'b0;
            r_halted       <= 1'b0;
        end else if (w_redir) begin
            r_halt_pending <= 1'b0;
        end else begin
            if (w_set_halt) begin
                r_halt_pending <= 1'b1;
            end
            if (r_halt_pending && (r_count == '0)) begin
                r_halted <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] r_stall_cnt;

    // Count cycles where decode holds off a valid instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!r_halted && out_valid && !out_ready
                     && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: memory model plus expected-instruction queue.
// Each task runs one scenario; handshakes are scored against the queue.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_rd_en;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redir_valid;
    logic [5:0]  redir_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [5:0]  out_pc;
    logic        out_ready;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [15:0] stall_cnt;
`endif

    typedef struct {
        logic [5:0]  pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [64];
    int          n_checks;
    int          n_fail;
    int          cyc;

    instr_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_rd_en (imem_rd_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .redir_valid(redir_valid),
        .redir_pc   (redir_pc),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_ready  (out_ready),
        .halted     (halted)
`ifdef FETCH_PERF_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: data one cycle after the read strobe.
    always @(posedge clk) begin
        imem_rdata <= imem_rd_en ? mem[imem_addr] : 32'hDEAD_BEEF;
    end

    task automatic fill_mem();
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
        end
    endtask

    task automatic exp_push(input int pc);
        exp_t e;
        e.pc    = 6'(pc);
        e.instr = mem[pc];
        sb.push_back(e);
    endtask

    // Negedge sample; scores a handshake that the next posedge will take.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got pc=%0d instr=%h, expected no output",
                         out_pc, out_instr);
            end else begin
                e = sb.pop_front();
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    n_fail++;
                    $display("FAIL sb_order: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                             out_pc, out_instr, e.pc, e.instr);
                end
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        while (sb.size() > 0 && b > 0) begin
            sample();
            if (sb.size() == 0) out_ready = 1'b0;
            advance();
            b--;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left, expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        out_ready   = 1'b1;
        redir_valid = 1'b0;
        redir_pc    = '0;
        @(posedge clk);
        #1;
        n_checks += 5;
        if (imem_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL rst_rd_en: got %b, expected 0", imem_rd_en);
        end
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_valid: got %b, expected 0", out_valid);
        end
        if (out_instr !== 32'h0) begin
            n_fail++; $display("FAIL rst_instr: got %h, expected 0", out_instr);
        end
        if (out_pc !== 6'h0) begin
            n_fail++; $display("FAIL rst_pc: got %0d, expected 0", out_pc);
        end
        if (halted !== 1'b0) begin
            n_fail++; $display("FAIL rst_halted: got %b, expected 0", halted);
        end
    endtask

    task automatic test_halt();
        int issues, first_v, first_h;
        fill_mem();
        mem[0] = 32'h0020_000A;
        mem[1] = 32'h0040_0014;
        mem[2] = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        apply_reset();
        exp_push(0);
        exp_push(1);
        issues  = 0;
        first_v = -1;
        first_h = -1;
        for (int c = 0; c < 12; c++) begin
            sample();
            if (imem_rd_en) issues++;
            if (out_valid && first_v < 0) first_v = cyc;
            if (halted && first_h < 0) first_h = cyc;
            if (cyc == 3) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_pc !== 6'd1) begin
                    n_fail++;
                    $display("FAIL halt_b2b: got valid=%b pc=%0d, expected valid=1 pc=1",
                             out_valid, out_pc);
                end
            end
            advance();
        end
        n_checks += 4;
        if (first_v != 2) begin
            n_fail++; $display("FAIL halt_latency: got cycle %0d, expected 2", first_v);
        end
        if (first_h != 5) begin
            n_fail++; $display("FAIL halt_cycle: got cycle %0d, expected 5", first_h);
        end
        if (issues != 3) begin
            n_fail++; $display("FAIL halt_issues: got %0d, expected 3", issues);
        end
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL halt_left: got %0d entries, expected 0", sb.size());
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (halted !== 1'b0) begin
            n_fail++; $display("FAIL halt_rst: got halted=%b, expected 0", halted);
        end
    endtask

    task automatic test_backpressure();
        int issues;
        fill_mem();
        out_ready = 1'b0;
        apply_reset();
        issues = 0;
        for (int c = 0; c < 5; c++) begin
            sample();
            if (imem_rd_en) issues++;
            if (c == 4) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_pc !== 6'd0) begin
                    n_fail++;
                    $display("FAIL bp_full: got valid=%b pc=%0d, expected valid=1 pc=0",
                             out_valid, out_pc);
                end
            end
            advance();
        end
        n_checks++;
        if (issues != 2) begin
            n_fail++; $display("FAIL bp_issues: got %0d, expected 2", issues);
        end
        for (int p = 0; p < 8; p++) exp_push(p);
        out_ready = 1'b1;
        sample();
        n_checks++;
        if (imem_rd_en !== 1'b1 || imem_addr !== 6'd2) begin
            n_fail++;
            $display("FAIL bp_resume: got rd_en=%b addr=%0d, expected rd_en=1 addr=2",
                     imem_rd_en, imem_addr);
        end
        advance();
        drain(30);
    endtask

    task automatic test_redirect();
        fill_mem();
        out_ready = 1'b1;
        apply_reset();
        exp_push(0);
        exp_push(1);
        for (int c = 0; c < 4; c++) begin
            sample();
            if (c == 3) begin
                n_checks++;
                if (imem_rd_en !== 1'b1 || imem_addr !== 6'd3) begin
                    n_fail++;
                    $display("FAIL redir_pre: got rd_en=%b addr=%0d, expected 1/3",
                             imem_rd_en, imem_addr);
                end
            end
            advance();
        end
        out_ready   = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = 6'd20;
        sample();
        n_checks++;
        if (imem_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL redir_noissue: got %b, expected 0", imem_rd_en);
        end
        advance();
        redir_valid = 1'b0;
        out_ready   = 1'b1;
        for (int p = 20; p < 24; p++) exp_push(p);
        sample();
        n_checks += 2;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_flush: got valid=%b, expected 0", out_valid);
        end
        if (imem_rd_en !== 1'b1 || imem_addr !== 6'd20) begin
            n_fail++;
            $display("FAIL redir_issue: got rd_en=%b addr=%0d, expected 1/20",
                     imem_rd_en, imem_addr);
        end
        advance();
        drain(20);
    endtask

    task automatic test_wrong_path();
        fill_mem();
        mem[4] = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        apply_reset();
        for (int p = 0; p < 4; p++) exp_push(p);
        for (int c = 0; c < 6; c++) begin
            sample();
            advance();
        end
        redir_valid = 1'b1;
        redir_pc    = 6'd10;
        sample();
        n_checks++;
        if (imem_rd_en !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL wp_redir: got rd_en=%b halted=%b, expected 0/0",
                     imem_rd_en, halted);
        end
        advance();
        redir_valid = 1'b0;
        for (int p = 10; p < 14; p++) exp_push(p);
        sample();
        n_checks++;
        if (imem_rd_en !== 1'b1 || imem_addr !== 6'd10) begin
            n_fail++;
            $display("FAIL wp_resume: got rd_en=%b addr=%0d, expected 1/10",
                     imem_rd_en, imem_addr);
        end
        advance();
        drain(20);
        n_checks++;
        if (halted !== 1'b0) begin
            n_fail++; $display("FAIL wp_halted: got %b, expected 0", halted);
        end
    endtask

    task automatic test_wrap();
        fill_mem();
        out_ready = 1'b1;
        apply_reset();
        redir_valid = 1'b1;
        redir_pc    = 6'd62;
        exp_push(62);
        exp_push(63);
        exp_push(0);
        exp_push(1);
        sample();
        n_checks++;
        if (imem_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL wrap_noissue: got %b, expected 0", imem_rd_en);
        end
        advance();
        redir_valid = 1'b0;
        drain(20);
    endtask

    task automatic test_reset_mid();
        fill_mem();
        out_ready = 1'b0;
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            sample();
            advance();
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_full: got valid=%b, expected 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || imem_rd_en !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst: got valid=%b rd_en=%b halted=%b, expected 0/0/0",
                     out_valid, imem_rd_en, halted);
        end
        out_ready = 1'b1;
        apply_reset();
        for (int p = 0; p < 4; p++) exp_push(p);
        sample();
        n_checks++;
        if (imem_rd_en !== 1'b1 || imem_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL mid_restart: got rd_en=%b addr=%0d, expected 1/0",
                     imem_rd_en, imem_addr);
        end
        advance();
        drain(20);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        out_ready = 1'b0;
        fill_mem();
        test_reset();
        test_halt();
        test_backpressure();
        test_redirect();
        test_wrong_path();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
